// File: rtl/l1_access_trace_gen.sv
// Trace generator for the L1 cache model: emits a bounded stream of addresses
// (sequential stride, LFSR random or looped stride) on a valid/ready request port.
module l1_access_trace_gen #(
   parameter int          ADDR_W    = 16,
   parameter int          LEN_W     = 10,
   parameter int          LOOP_LEN  = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  trace_len,
   output logic              req_valid,
   output logic [ADDR_W-1:0] req_addr,
   input  logic              req_ready,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  issued_count
);

   localparam int                LIDX_W    = (LOOP_LEN > 1) ? $clog2(LOOP_LEN) : 1;
   localparam logic [LIDX_W-1:0] LIDX_LAST = LIDX_W'(LOOP_LEN - 1);
   localparam logic [1:0]        MODE_RAND = 2'd1;
   localparam logic [1:0]        MODE_LOOP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_nextState;

   logic [1:0]          r_mode;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_stride;
   logic [LEN_W-1:0]    r_len;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_W-1:0]    r_count;
   logic [15:0]         r_lfsr;
   logic [LIDX_W-1:0]   r_loopIdx;

   logic                w_startTrace;
   logic                w_handshake;
   logic                w_lastBeat;
   logic                w_lfsrFb;
   logic [15:0]         w_lfsrNext;

   assign w_startTrace = (r_state == S_IDLE) && start;
   assign w_handshake  = (r_state == S_RUN) && req_ready;
   assign w_lastBeat   = w_handshake && ((r_count + LEN_W'(1)) == r_len);

   // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifted left into bit 0
   assign w_lfsrFb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_lfsrNext = {r_lfsr[14:0], w_lfsrFb};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      req_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nextState = (trace_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            req_valid = 1'b1;
            busy      = 1'b1;
            if (w_lastBeat) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Config is captured only at start so later input changes cannot disturb a running trace;
   // the address register always holds the address of the next (or pending) request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode    <= 2'd0;
         r_base    <= '0;
         r_stride  <= '0;
         r_len     <= '0;
         r_addr    <= '0;
         r_count   <= '0;
         r_lfsr    <= LFSR_SEED;
         r_loopIdx <= '0;
      end else if (w_startTrace) begin
         r_mode    <= mode;
         r_base    <= base_addr;
         r_stride  <= stride;
         r_len     <= trace_len;
         r_count   <= '0;
         r_lfsr    <= LFSR_SEED;
         r_loopIdx <= '0;
         r_addr    <= (mode == MODE_RAND) ? LFSR_SEED[ADDR_W-1:0] : base_addr;
      end else if (w_handshake) begin
         r_count <= r_count + LEN_W'(1);
         case (r_mode)
            MODE_RAND: begin
               r_lfsr <= w_lfsrNext;
               r_addr <= w_lfsrNext[ADDR_W-1:0];
            end
            MODE_LOOP: begin
               if (r_loopIdx == LIDX_LAST) begin
                  r_loopIdx <= '0;
                  r_addr    <= r_base;
               end else begin
                  r_loopIdx <= r_loopIdx + LIDX_W'(1);
                  r_addr    <= r_addr + r_stride;
               end
            end
            default: begin
               r_addr <= r_addr + r_stride;
            end
         endcase
      end
   end

   assign req_addr     = r_addr;
   assign issued_count = r_count;

endmodule
